// File: rtl/time_set_ctrl_if.sv
// Button, live-time and load/blank signals between the time-set controller and
// the clock datapath; the controller takes the slave side.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       blink_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       run_en;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       load;
    logic       blank_hour;
    logic       blank_min;
    logic [1:0] mode_state;

    modport master (
        output btn_mode, btn_inc, blink_tick, cur_hour, cur_min,
        input  run_en, set_hour, set_min, load, blank_hour, blank_min, mode_state
    );

    modport slave (
        input  btn_mode, btn_inc, blink_tick, cur_hour, cur_min,
        output run_en, set_hour, set_min, load, blank_hour, blank_min, mode_state
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: MODE/INC edit sequence RUN -> SET_HOUR -> SET_MIN -> RUN.
// Define AUTO_REPEAT_EN to add auto-repeat of INC while it is held.
module time_set_ctrl #(
    parameter int          HOUR_MOD   = 24,
    parameter int          MIN_MOD    = 60,
    parameter logic [15:0] REPEAT_DLY = 16'd500,
    parameter logic [15:0] REPEAT_PER = 16'd100
) (
    input  logic           clk,
    input  logic           glob_rst_n,
    time_set_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);
    localparam logic [5:0] MIN_MAX  = 6'(MIN_MOD - 1);

    state_t     state, state_next;
    logic       mode_q, inc_q;
    logic       phase, phase_next;
    logic [4:0] hour_r, hour_next;
    logic [5:0] min_r, min_next;
    logic       load_r, load_next;
    logic       mode_ev, inc_ev, inc_fire, editing;

    assign mode_ev = bus.btn_mode & ~mode_q;
    assign inc_ev  = bus.btn_inc & ~inc_q;
    assign editing = (state == SET_HOUR) || (state == SET_MIN);

`ifdef AUTO_REPEAT_EN
    logic [15:0] rep_cnt, rep_cnt_next;
    logic        rep_on, rep_on_next;
    logic        rep_fire;
    logic [15:0] rep_limit;

    // rep_cnt holds cycles since the press (or last repeat); zero means no armed press.
    assign rep_limit = rep_on ? REPEAT_PER : REPEAT_DLY;
    assign rep_fire  = editing && bus.btn_inc && inc_q &&
                       (rep_cnt != 16'd0) && (rep_cnt == rep_limit);

    always_comb begin
        rep_cnt_next = rep_cnt;
        rep_on_next  = rep_on;
        if ((state_next != state) || !editing || !bus.btn_inc) begin
            rep_cnt_next = 16'd0;
            rep_on_next  = 1'b0;
        end else if (inc_ev) begin
            rep_cnt_next = 16'd1;
            rep_on_next  = 1'b0;
        end else if (rep_cnt != 16'd0) begin
            if (rep_fire) begin
                rep_cnt_next = 16'd1;
                rep_on_next  = 1'b1;
            end else begin
                rep_cnt_next = rep_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!glob_rst_n) begin
            rep_cnt <= 16'd0;
            rep_on  <= 1'b0;
        end else begin
            rep_cnt <= rep_cnt_next;
            rep_on  <= rep_on_next;
        end
    end

    assign inc_fire = inc_ev | rep_fire;
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DLY, REPEAT_PER};
    assign inc_fire      = inc_ev;
`endif

    always_ff @(posedge clk) begin
        if (!glob_rst_n) begin
            state  <= RUN;
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
            phase  <= 1'b0;
            hour_r <= 5'd0;
            min_r  <= 6'd0;
            load_r <= 1'b0;
        end else begin
            state  <= state_next;
            mode_q <= bus.btn_mode;
            inc_q  <= bus.btn_inc;
            phase  <= phase_next;
            hour_r <= hour_next;
            min_r  <= min_next;
            load_r <= load_next;
        end
    end

    // MODE is checked before INC so a simultaneous INC event is dropped.
    always_comb begin
        state_next = state;
        hour_next  = hour_r;
        min_next   = min_r;
        load_next  = 1'b0;
        case (state)
            RUN: begin
                if (mode_ev) begin
                    state_next = SET_HOUR;
                    hour_next  = bus.cur_hour;
                    min_next   = bus.cur_min;
                end
            end
            SET_HOUR: begin
                if (mode_ev) begin
                    state_next = SET_MIN;
                end else if (inc_fire) begin
                    hour_next = (hour_r == HOUR_MAX) ? 5'd0 : hour_r + 5'd1;
                end
            end
            SET_MIN: begin
                if (mode_ev) begin
                    state_next = RUN;
                    load_next  = 1'b1;
                end else if (inc_fire) begin
                    min_next = (min_r == MIN_MAX) ? 6'd0 : min_r + 6'd1;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        phase_next = phase ^ bus.blink_tick;
        if (state_next != state) begin
            phase_next = 1'b0;
        end
    end

    assign bus.run_en     = (state == RUN);
    assign bus.set_hour   = hour_r;
    assign bus.set_min    = min_r;
    assign bus.load       = load_r;
    assign bus.blank_hour = phase & (state == SET_HOUR);
    assign bus.blank_min  = phase & (state == SET_MIN);
    assign bus.mode_state = state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl; honours AUTO_REPEAT_EN
// for the held-INC expectation.
module tb_time_set_ctrl;

    logic clk = 1'b0;
    logic glob_rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .HOUR_MOD  (24),
        .MIN_MOD   (60),
        .REPEAT_DLY(16'd10),
        .REPEAT_PER(16'd4)
    ) dut (
        .clk       (clk),
        .glob_rst_n(glob_rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle INC press followed by one cycle released.
    task automatic press_inc();
        bus.btn_inc = 1'b1;
        tick(1);
        bus.btn_inc = 1'b0;
        tick(1);
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        tick(1);
        bus.btn_mode = 1'b0;
        tick(1);
    endtask

    initial begin
        bus.btn_mode   = 1'b0;
        bus.btn_inc    = 1'b0;
        bus.blink_tick = 1'b0;
        bus.cur_hour   = 5'd0;
        bus.cur_min    = 6'd0;

        tick(2);
        glob_rst_n = 1'b1;
        tick(10);
        check("reset_state", 32'(bus.mode_state), 0);
        check("reset_run_en", 32'(bus.run_en), 1);
        check("reset_load", 32'(bus.load), 0);
        check("reset_set_hour", 32'(bus.set_hour), 0);
        check("reset_set_min", 32'(bus.set_min), 0);
        check("reset_blank_hour", 32'(bus.blank_hour), 0);

        // INC in RUN is ignored
        press_inc();
        check("run_inc_state", 32'(bus.mode_state), 0);
        check("run_inc_hour", 32'(bus.set_hour), 0);

        // Enter SET_HOUR capturing 13:45
        bus.cur_hour = 5'd13;
        bus.cur_min  = 6'd45;
        bus.btn_mode = 1'b1;
        tick(1);
        check("enter_state", 32'(bus.mode_state), 1);
        check("enter_hour", 32'(bus.set_hour), 13);
        check("enter_min", 32'(bus.set_min), 45);
        check("enter_run_en", 32'(bus.run_en), 0);
        tick(2);
        check("mode_held_once", 32'(bus.mode_state), 1);
        bus.btn_mode = 1'b0;
        tick(1);

        for (int i = 0; i < 9; i++) press_inc();
        check("hour_22", 32'(bus.set_hour), 22);
        press_inc();
        check("hour_23", 32'(bus.set_hour), 23);
        press_inc();
        check("hour_wrap_0", 32'(bus.set_hour), 0);
        press_inc();
        check("hour_1", 32'(bus.set_hour), 1);

        // Blink phase toggles only for the edited field
        bus.blink_tick = 1'b1;
        tick(1);
        bus.blink_tick = 1'b0;
        check("blank_hour_on", 32'(bus.blank_hour), 1);
        check("blank_min_off", 32'(bus.blank_min), 0);

        press_mode();
        check("to_set_min", 32'(bus.mode_state), 2);
        check("blank_cleared", 32'(bus.blank_min), 0);
        check("hour_kept", 32'(bus.set_hour), 1);

        for (int i = 0; i < 13; i++) press_inc();
        check("min_58", 32'(bus.set_min), 58);
        press_inc();
        check("min_59", 32'(bus.set_min), 59);
        press_inc();
        check("min_wrap_0", 32'(bus.set_min), 0);

        bus.btn_mode = 1'b1;
        tick(1);
        bus.btn_mode = 1'b0;
        check("exit_state", 32'(bus.mode_state), 0);
        check("exit_load", 32'(bus.load), 1);
        check("exit_run_en", 32'(bus.run_en), 1);
        check("exit_hour", 32'(bus.set_hour), 1);
        check("exit_min", 32'(bus.set_min), 0);
        tick(1);
        check("load_one_cycle", 32'(bus.load), 0);
        check("run_hold_hour", 32'(bus.set_hour), 1);

        // MODE and INC together in SET_HOUR: MODE wins
        bus.cur_hour = 5'd5;
        bus.cur_min  = 6'd30;
        press_mode();
        check("simul_pre_hour", 32'(bus.set_hour), 5);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        tick(1);
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        check("simul_state", 32'(bus.mode_state), 2);
        check("simul_hour", 32'(bus.set_hour), 5);
        tick(1);
        check("simul_min", 32'(bus.set_min), 30);

        // Reset mid-edit: back to RUN, values discarded, no load
        glob_rst_n = 1'b0;
        tick(1);
        check("rst_edit_state", 32'(bus.mode_state), 0);
        check("rst_edit_min", 32'(bus.set_min), 0);
        check("rst_edit_load", 32'(bus.load), 0);
        glob_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("rst_no_load", 32'(bus.load), 0);
        end

        // MODE held across reset counts as a fresh press
        bus.cur_hour = 5'd7;
        bus.cur_min  = 6'd0;
        bus.btn_mode = 1'b1;
        glob_rst_n   = 1'b0;
        tick(1);
        check("held_rst_state", 32'(bus.mode_state), 0);
        glob_rst_n = 1'b1;
        tick(1);
        check("held_rst_press", 32'(bus.mode_state), 1);
        check("held_rst_hour", 32'(bus.set_hour), 7);
        bus.btn_mode = 1'b0;
        tick(1);

        press_mode();
        check("hold_pre_state", 32'(bus.mode_state), 2);
        check("hold_pre_min", 32'(bus.set_min), 0);

        // Hold INC for 30 cycles in SET_MIN
        bus.btn_inc = 1'b1;
        tick(30);
        bus.btn_inc = 1'b0;
        tick(2);
`ifdef AUTO_REPEAT_EN
        check("hold_inc_min", 32'(bus.set_min), 6);
`else
        check("hold_inc_min", 32'(bus.set_min), 1);
`endif
        check("hold_inc_state", 32'(bus.mode_state), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User time-setting controller for the digital clock: the write side of the hour/minute counter chain, complementing the count-and-display path. It turns two button levels (MODE, INC) into an edit sequence RUN → SET_HOUR → SET_MIN → RUN. On exit it presents new hour/minute values with a one-cycle load strobe to the hour and minute counters. While editing it gates the counters' count enable off and drives a blink mask for the seven-segment digits being edited.

## Interface

Parameters:
- HOUR_MOD, 24, hour modulus; edit value wraps HOUR_MOD-1 → 0
- MIN_MOD, 60, minute modulus; edit value wraps MIN_MOD-1 → 0
- REPEAT_DLY, 16'd500, cycles INC must be held before auto-repeat starts (AUTO_REPEAT_EN only)
- REPEAT_PER, 16'd100, cycles between auto-repeat increments (AUTO_REPEAT_EN only)

Ports:
- clk  input  1  system clock; all state on rising edge
- glob_rst_n  input  1  synchronous, active-low reset
- btn_mode  input  1  MODE button level, already synchronized/debounced, active-high
- btn_inc  input  1  INC button level, already synchronized/debounced, active-high
- blink_tick  input  1  one-cycle pulse toggling blink phase (e.g. 2 Hz)
- cur_hour  input  5  live hour counter value, 0..HOUR_MOD-1
- cur_min  input  6  live minute counter value, 0..MIN_MOD-1
- run_en  output  1  count enable to time counters; 1 only in RUN
- set_hour  output  5  hour value to load
- set_min  output  6  minute value to load
- load  output  1  one-cycle strobe: counters load set_hour/set_min; seconds clear
- blank_hour  output  1  1 = blank both hour digits (blink off phase)
- blank_min  output  1  1 = blank both minute digits
- mode_state  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 unused)

## Operation

- Edge detect: registered copies of btn_mode/btn_inc; press event = level 1 and previous 0. Holding a button yields exactly one event (unless auto-repeat).
- States:
  - RUN: run_en=1, no blanking.
    - MODE event → SET_HOUR; set_hour←cur_hour, set_min←cur_min captured in the same edge.
    - INC ignored.
  - SET_HOUR: run_en=0.
    - INC event → set_hour+1, wraps HOUR_MOD-1 → 0.
    - MODE event → SET_MIN.
  - SET_MIN: run_en=0.
    - INC event → set_min+1, wraps MIN_MOD-1 → 0.
    - MODE event → RUN with load=1.
  - Encoding 11 → RUN next cycle, no load.
- Blink: phase register toggles on blink_tick; cleared to 0 on every state change.
  - blank_hour = phase & (state==SET_HOUR); blank_min = phase & (state==SET_MIN).
- Simultaneous MODE and INC events: MODE wins; INC discarded that cycle.
- Arithmetic: compare-then-reset (value==MOD-1 ? 0 : value+1); never produces ≥ MOD.
- set_hour/set_min hold their values in RUN (last loaded/captured).

## Timing

- Reset (glob_rst_n=0 at edge): state=RUN, run_en=1, set_hour=0, set_min=0, load=0, blank_*=0, blink phase=0, edge registers=0, repeat counter=0.
- A press sampled at edge N (previous sample 0) takes effect at edge N; new state/value visible after edge N.
- run_en drops the cycle after the MODE edge that leaves RUN. Counters may have counted on that same edge; the captured value is pre-increment.
- load is high for exactly one cycle, the first cycle in RUN; run_en is 1 in that cycle. Counters give load priority over ce.
- Reset mid-edit: return to RUN immediately; edited values discarded; no load pulse.
- Button held across reset: the edge register is cleared, so a level still high after reset counts as a new press.

## Configuration

- AUTO_REPEAT_EN defined: in SET_HOUR/SET_MIN, INC held continuously REPEAT_DLY cycles after its press event generates one extra increment. Then one more every REPEAT_PER cycles while held.
  - Repeat counter is 16 bits, clears on release, on state change and on reset.
  - A MODE event in the same cycle suppresses the repeat increment.
- Not defined: no repeat logic, no repeat counter; REPEAT_* unused; one increment per press.

## Test plan

- Reset then idle 10 cycles → mode_state=00, run_en=1, load=0, set_hour=0, set_min=0.
- cur_hour=13, cur_min=45; MODE press → mode_state=01, set_hour=13, set_min=45, run_en=0 after the edge.
- In SET_HOUR from 22: 3 INC presses → 23, 0, 1; MODE → SET_MIN; from 58, 2 INC → 59, 0; MODE → RUN with load=1 for one cycle, set_hour=1, set_min=0.
- MODE and INC rising in the same cycle in SET_HOUR at 5 → state SET_MIN, set_hour stays 5.
- glob_rst_n low for one cycle while in SET_MIN with set_min=30 → RUN, set_min=0, load never asserted.
- AUTO_REPEAT_EN, REPEAT_DLY=10, REPEAT_PER=4: hold INC 30 cycles in SET_MIN from 0 → increments at press, +10, +14, +18, +22, +26 → set_min=6. Without the macro → set_min=1.
